match_score_engine: RTL and testbench

MATCH_SCORE_ENGINE -- requirements
Module: match_score_engine

---
 rtl/match_score_engine.sv | 166 ++++++++++++++++
 tb/tb_match_score_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_score_engine.sv
// Point/set/match scoreboard for a two-team rally-scored match.
// Tracks points, sets, serve, and the set/match win sequencing.
module match_score_engine #(
  parameter int unsigned PTS_SET     = 25,
  parameter int unsigned PTS_TIE     = 15,
  parameter int unsigned SETS_TO_WIN = 3,
  parameter int unsigned MIN_LEAD    = 2,
  parameter int unsigned PNT_W       = 6,
  parameter int unsigned SET_W       = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [1:0]       pnt_inc,
  input  logic [1:0]       pnt_dec,
  input  logic             new_match,
  output logic [PNT_W-1:0] pnt1,
  output logic [PNT_W-1:0] pnt2,
  output logic [SET_W-1:0] set1,
  output logic [SET_W-1:0] set2,
  output logic [2:0]       set_num,
  output logic             serve,
  output logic             set_won,
  output logic             set_winner,
  output logic             match_over,
  output logic             match_winner,
  output logic             conflict
);

  localparam int unsigned PNT_MAX = (1 << PNT_W) - 1;

  typedef enum logic [1:0] {StPlay, StSetEnd, StMatchEnd} state_e;

  state_e           st_q, st_d;
  logic [PNT_W-1:0] pnt1_q, pnt1_d, pnt2_q, pnt2_d;
  logic [SET_W-1:0] set1_q, set1_d, set2_q, set2_d;
  logic [2:0]       set_num_q, set_num_d;
  logic             serve_q, serve_d;
  logic             winner_q, winner_d;
  logic             conflict_q, conflict_d;

  logic [3:0]       req;
  logic             multi;
  int unsigned      target;
  logic [PNT_W-1:0] inc1, inc2;
  logic             win1, win2;
  logic [SET_W-1:0] winner_sets;

  assign req   = {pnt_dec, pnt_inc};
  assign multi = (req & (req - 4'd1)) != 4'd0;

  assign target = (32'(set1_q) == SETS_TO_WIN - 1 && 32'(set2_q) == SETS_TO_WIN - 1) ?
                  PTS_TIE : PTS_SET;

  // Saturating increments; the win test is made on the post-increment value.
  assign inc1 = (pnt1_q == PNT_W'(PNT_MAX)) ? pnt1_q : pnt1_q + 1'b1;
  assign inc2 = (pnt2_q == PNT_W'(PNT_MAX)) ? pnt2_q : pnt2_q + 1'b1;
  assign win1 = (32'(inc1) >= target) && (32'(inc1) >= 32'(pnt2_q) + MIN_LEAD);
  assign win2 = (32'(inc2) >= target) && (32'(inc2) >= 32'(pnt1_q) + MIN_LEAD);

  assign winner_sets = winner_q ? set2_q : set1_q;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      st_q       <= StPlay;
      pnt1_q     <= '0;
      pnt2_q     <= '0;
      set1_q     <= '0;
      set2_q     <= '0;
      set_num_q  <= 3'd1;
      serve_q    <= 1'b0;
      winner_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      pnt1_q     <= pnt1_d;
      pnt2_q     <= pnt2_d;
      set1_q     <= set1_d;
      set2_q     <= set2_d;
      set_num_q  <= set_num_d;
      serve_q    <= serve_d;
      winner_q   <= winner_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    pnt1_d     = pnt1_q;
    pnt2_d     = pnt2_q;
    set1_d     = set1_q;
    set2_d     = set2_q;
    set_num_d  = set_num_q;
    serve_d    = serve_q;
    winner_d   = winner_q;
    conflict_d = 1'b0;
    unique case (st_q)
      StPlay: begin
        if (multi) begin
          conflict_d = 1'b1;
        end else begin
          case (req)
            4'b0001: begin
              pnt1_d  = inc1;
              serve_d = 1'b0;
              if (win1) begin
                set1_d   = set1_q + 1'b1;
                winner_d = 1'b0;
                st_d     = StSetEnd;
              end
            end
            4'b0010: begin
              pnt2_d  = inc2;
              serve_d = 1'b1;
              if (win2) begin
                set2_d   = set2_q + 1'b1;
                winner_d = 1'b1;
                st_d     = StSetEnd;
              end
            end
            4'b0100: if (pnt1_q != '0) pnt1_d = pnt1_q - 1'b1;
            4'b1000: if (pnt2_q != '0) pnt2_d = pnt2_q - 1'b1;
            default: ;
          endcase
        end
      end
      StSetEnd: begin
        if (winner_sets == SET_W'(SETS_TO_WIN)) begin
          st_d = StMatchEnd;
        end else begin
          pnt1_d    = '0;
          pnt2_d    = '0;
          set_num_d = set_num_q + 3'd1;
          st_d      = StPlay;
        end
      end
      StMatchEnd: ;
      default: st_d = StPlay;
    endcase
    if (new_match) begin
      st_d       = StPlay;
      pnt1_d     = '0;
      pnt2_d     = '0;
      set1_d     = '0;
      set2_d     = '0;
      set_num_d  = 3'd1;
      serve_d    = 1'b0;
      winner_d   = 1'b0;
      conflict_d = 1'b0;
    end
  end

  always_comb begin
    pnt1         = pnt1_q;
    pnt2         = pnt2_q;
    set1         = set1_q;
    set2         = set2_q;
    set_num      = set_num_q;
    serve        = serve_q;
    set_won      = (st_q == StSetEnd);
    set_winner   = (st_q == StSetEnd) & winner_q;
    match_over   = (st_q == StMatchEnd);
    match_winner = (st_q == StMatchEnd) & winner_q;
    conflict     = conflict_q;
  end

endmodule

// File: tb/tb_match_score_engine.sv
// Directed bench for match_score_engine: a vector table for in-set scoring
// plus hand sequences for set wins, deuce, deciding set, match end and reset.
module tb_match_score_engine;

  logic       clk;
  logic       rst_n;
  logic [1:0] pnt_inc;
  logic [1:0] pnt_dec;
  logic       new_match;
  logic [5:0] pnt1, pnt2;
  logic [1:0] set1, set2;
  logic [2:0] set_num;
  logic       serve, set_won, set_winner, match_over, match_winner, conflict;

  int total = 0;
  int passed = 0;

  match_score_engine dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .pnt_inc     (pnt_inc),
    .pnt_dec     (pnt_dec),
    .new_match   (new_match),
    .pnt1        (pnt1),
    .pnt2        (pnt2),
    .set1        (set1),
    .set2        (set2),
    .set_num     (set_num),
    .serve       (serve),
    .set_won     (set_won),
    .set_winner  (set_winner),
    .match_over  (match_over),
    .match_winner(match_winner),
    .conflict    (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] inc;
    logic [1:0] dec;
    logic       nm;
    int         p1;
    int         p2;
    logic       srv;
    logic       cf;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic cyc(input logic [1:0] i, input logic [1:0] d, input logic nm);
    pnt_inc   = i;
    pnt_dec   = d;
    new_match = nm;
    @(posedge clk);
    #1;
    pnt_inc   = 2'b00;
    pnt_dec   = 2'b00;
    new_match = 1'b0;
  endtask

  task automatic score(input int team, input int n);
    for (int k = 0; k < n; k++) cyc(team == 1 ? 2'b01 : 2'b10, 2'b00, 1'b0);
  endtask

  task automatic alternate(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(2'b01, 2'b00, 1'b0);
      cyc(2'b10, 2'b00, 1'b0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pnt1"}, int'(pnt1), 0);
    chk({tag, " pnt2"}, int'(pnt2), 0);
    chk({tag, " set1"}, int'(set1), 0);
    chk({tag, " set2"}, int'(set2), 0);
    chk({tag, " set_num"}, int'(set_num), 1);
    chk({tag, " serve"}, int'(serve), 0);
    chk({tag, " set_won"}, int'(set_won), 0);
    chk({tag, " set_winner"}, int'(set_winner), 0);
    chk({tag, " match_over"}, int'(match_over), 0);
    chk({tag, " match_winner"}, int'(match_winner), 0);
    chk({tag, " conflict"}, int'(conflict), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pnt_inc   = 2'b00;
    pnt_dec   = 2'b00;
    new_match = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    tbl[0]  = '{2'b01, 2'b00, 1'b0, 1, 0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 1'b0, 2, 0, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 2'b00, 1'b0, 2, 1, 1'b1, 1'b0};
    tbl[3]  = '{2'b01, 2'b00, 1'b0, 3, 1, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 2'b00, 1'b0, 3, 2, 1'b1, 1'b0};
    tbl[5]  = '{2'b10, 2'b00, 1'b0, 3, 3, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 2'b00, 1'b0, 3, 3, 1'b1, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 1'b0, 3, 3, 1'b1, 1'b0};
    tbl[8]  = '{2'b01, 2'b10, 1'b0, 3, 3, 1'b1, 1'b1};
    tbl[9]  = '{2'b00, 2'b01, 1'b0, 2, 3, 1'b1, 1'b0};
    tbl[10] = '{2'b00, 2'b11, 1'b0, 2, 3, 1'b1, 1'b1};
    tbl[11] = '{2'b01, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[13] = '{2'b10, 2'b00, 1'b0, 0, 1, 1'b1, 1'b0};
    tbl[14] = '{2'b10, 2'b00, 1'b0, 0, 2, 1'b1, 1'b0};
    tbl[15] = '{2'b10, 2'b00, 1'b0, 0, 3, 1'b1, 1'b0};
    tbl[16] = '{2'b10, 2'b00, 1'b0, 0, 4, 1'b1, 1'b0};
    tbl[17] = '{2'b10, 2'b00, 1'b0, 0, 5, 1'b1, 1'b0};
    tbl[18] = '{2'b00, 2'b01, 1'b0, 0, 5, 1'b1, 1'b0};
    tbl[19] = '{2'b00, 2'b10, 1'b0, 0, 4, 1'b1, 1'b0};

    for (int v = 0; v < 20; v++) begin
      cyc(tbl[v].inc, tbl[v].dec, tbl[v].nm);
      chk($sformatf("vec%0d pnt1", v), int'(pnt1), tbl[v].p1);
      chk($sformatf("vec%0d pnt2", v), int'(pnt2), tbl[v].p2);
      chk($sformatf("vec%0d serve", v), int'(serve), int'(tbl[v].srv));
      chk($sformatf("vec%0d conflict", v), int'(conflict), int'(tbl[v].cf));
      chk($sformatf("vec%0d set_won", v), int'(set_won), 0);
    end

    // Straight set win for team 1.
    cyc(2'b00, 2'b00, 1'b1);
    score(1, 24);
    chk("s1 24-0 set_won", int'(set_won), 0);
    score(1, 1);
    chk("s1 set_won", int'(set_won), 1);
    chk("s1 set_winner", int'(set_winner), 0);
    chk("s1 pnt1", int'(pnt1), 25);
    chk("s1 set1", int'(set1), 1);
    cyc(2'b00, 2'b00, 1'b0);
    chk("s1 after pnt1", int'(pnt1), 0);
    chk("s1 after pnt2", int'(pnt2), 0);
    chk("s1 after set_num", int'(set_num), 2);
    chk("s1 after set_won", int'(set_won), 0);

    // Deuce: 24-24, 25-24 is not enough, 26-24 wins.
    alternate(24);
    chk("deuce pnt1", int'(pnt1), 24);
    chk("deuce pnt2", int'(pnt2), 24);
    score(1, 1);
    chk("deuce 25-24 set_won", int'(set_won), 0);
    chk("deuce 25-24 pnt1", int'(pnt1), 25);
    score(1, 1);
    chk("deuce 26-24 set_won", int'(set_won), 1);
    chk("deuce 26-24 pnt1", int'(pnt1), 26);
    chk("deuce set1", int'(set1), 2);
    cyc(2'b00, 2'b00, 1'b0);
    chk("deuce set_num", int'(set_num), 3);

    // Team 2 takes sets 3 and 4, inputs during SET_END ignored.
    score(2, 25);
    chk("s3 set_winner", int'(set_winner), 1);
    cyc(2'b10, 2'b00, 1'b0);
    chk("s3 setend ignores pnt2", int'(pnt2), 0);
    score(2, 25);
    cyc(2'b00, 2'b00, 1'b0);
    chk("s5 set_num", int'(set_num), 5);
    chk("s5 set1", int'(set1), 2);
    chk("s5 set2", int'(set2), 2);

    // Deciding set to 15.
    alternate(13);
    score(2, 1);
    chk("tie 13-14 set_won", int'(set_won), 0);
    score(2, 1);
    chk("tie set_won", int'(set_won), 1);
    chk("tie set_winner", int'(set_winner), 1);
    chk("tie set2", int'(set2), 3);
    cyc(2'b00, 2'b00, 1'b0);
    chk("match_over", int'(match_over), 1);
    chk("match_winner", int'(match_winner), 1);
    chk("match pnt2 held", int'(pnt2), 15);
    chk("match pnt1 held", int'(pnt1), 13);
    cyc(2'b11, 2'b00, 1'b0);
    chk("match conflict suppressed", int'(conflict), 0);
    cyc(2'b01, 2'b00, 1'b0);
    chk("match ignores inc", int'(pnt1), 13);
    chk("match still over", int'(match_over), 1);

    // Undo does not move serve, then new_match beats a point pulse.
    cyc(2'b00, 2'b00, 1'b1);
    score(2, 11);
    score(1, 10);
    chk("undo pre serve", int'(serve), 0);
    cyc(2'b00, 2'b10, 1'b0);
    chk("undo pnt1", int'(pnt1), 10);
    chk("undo pnt2", int'(pnt2), 10);
    chk("undo serve", int'(serve), 0);
    cyc(2'b01, 2'b00, 1'b1);
    chk_reset_state("new_match");

    // Reset during SET_END aborts the set.
    score(1, 25);
    chk("abort set_won", int'(set_won), 1);
    rst_n = 1'b0;
    cyc(2'b00, 2'b00, 1'b0);
    rst_n = 1'b1;
    chk_reset_state("abort");
    cyc(2'b00, 2'b00, 1'b0);
    chk("abort no late set_won", int'(set_won), 0);
    chk("abort set1 stays", int'(set1), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
